cdb_broadcast_arbiter: RTL

Transmit side of the result-broadcast interface. The ROB and the reservation stations consume (valid, tag, value) results. This block collects results from four producers: ALU1 (src 0), ALU2 (src 1), load port 1 (src 2) and load port 2 (src 3). It buffers each producer in a small per-source FIFO and drives at most two registered broadcast lanes per cycle, using round-robin arbitration with producer backpressure.

---
 rtl/cdb_broadcast_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cdb_broadcast_arbiter.sv
// rtl/cdb_broadcast_arbiter.sv - four-producer result FIFOs feeding two registered CDB lanes
// Round-robin picks up to two FIFO heads per cycle; the rr pointer moves past the last source served.
module cdb_broadcast_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [3:0]            src_valid,
  input  logic [4*TAG_W-1:0]    src_tag,
  input  logic [4*DATA_W-1:0]   src_value,
  output logic [3:0]            src_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_value,
  output logic [1:0]            cdb_src,
  output logic                  cdb_valid2,
  output logic [TAG_W-1:0]      cdb_tag2,
  output logic [DATA_W-1:0]     cdb_value2,
  output logic [1:0]            cdb_src2,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W-1:0]  r_tag_mem [4][DEPTH];
  logic [DATA_W-1:0] r_val_mem [4][DEPTH];
  logic [AW-1:0]     r_rd_ptr  [4];
  logic [AW-1:0]     r_wr_ptr  [4];
  logic [CW-1:0]     r_cnt     [4];
  logic [1:0]        r_rr;

  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_value;
  logic [1:0]        r_cdb_src;
  logic              r_cdb_valid2;
  logic [TAG_W-1:0]  r_cdb_tag2;
  logic [DATA_W-1:0] r_cdb_value2;
  logic [1:0]        r_cdb_src2;

  logic [3:0]        w_ne;
  logic [3:0]        w_full;
  logic [3:0]        w_push;
  logic [3:0]        w_pop;
  logic [1:0]        w_g0;
  logic [1:0]        w_g1;
  logic              w_f0;
  logic              w_f1;
  logic [1:0]        w_last;
  logic [TAG_W-1:0]  w_h0_tag;
  logic [TAG_W-1:0]  w_h1_tag;
  logic [DATA_W-1:0] w_h0_val;
  logic [DATA_W-1:0] w_h1_val;

  always_comb begin
    w_ne   = '0;
    w_full = '0;
    for (int i = 0; i < 4; i++) begin
      w_ne[i]   = (r_cnt[i] != '0);
      w_full[i] = (r_cnt[i] == CW'(DEPTH));
    end
  end

  // Readiness looks only at the registered count, so a full FIFO stalls even if it pops this cycle.
  assign src_ready = ~w_full & {4{~flush}};
  assign w_push    = src_valid & src_ready;

  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    w_g0  = '0;
    w_g1  = '0;
    w_f0  = 1'b0;
    w_f1  = 1'b0;
    w_pop = '0;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr + 2'(k);
      if (w_ne[idx]) begin
        if (!w_f0) begin
          w_g0 = idx;
          w_f0 = 1'b1;
        end else if (!w_f1) begin
          w_g1 = idx;
          w_f1 = 1'b1;
        end
      end
    end
    if (w_f0) w_pop[w_g0] = 1'b1;
    if (w_f1) w_pop[w_g1] = 1'b1;
  end

  assign w_last   = w_f1 ? w_g1 : w_g0;
  assign w_h0_tag = r_tag_mem[w_g0][r_rd_ptr[w_g0]];
  assign w_h0_val = r_val_mem[w_g0][r_rd_ptr[w_g0]];
  assign w_h1_tag = r_tag_mem[w_g1][r_rd_ptr[w_g1]];
  assign w_h1_val = r_val_mem[w_g1][r_rd_ptr[w_g1]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_wr_ptr[i]] <= src_tag[i*TAG_W +: TAG_W];
        r_val_mem[i][r_wr_ptr[i]] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < 4; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_rr         <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= '0;
      r_cdb_valid2 <= 1'b0;
      r_cdb_tag2   <= '0;
      r_cdb_value2 <= '0;
      r_cdb_src2   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      r_cdb_valid  <= w_f0;
      r_cdb_tag    <= w_f0 ? w_h0_tag : '0;
      r_cdb_value  <= w_f0 ? w_h0_val : '0;
      r_cdb_src    <= w_f0 ? w_g0 : '0;
      r_cdb_valid2 <= w_f1;
      r_cdb_tag2   <= w_f1 ? w_h1_tag : '0;
      r_cdb_value2 <= w_f1 ? w_h1_val : '0;
      r_cdb_src2   <= w_f1 ? w_g1 : '0;
      if (w_f0) r_rr <= w_last + 2'd1;
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_tag    = r_cdb_tag;
  assign cdb_value  = r_cdb_value;
  assign cdb_src    = r_cdb_src;
  assign cdb_valid2 = r_cdb_valid2;
  assign cdb_tag2   = r_cdb_tag2;
  assign cdb_value2 = r_cdb_value2;
  assign cdb_src2   = r_cdb_src2;
  assign busy       = (|w_ne) | r_cdb_valid | r_cdb_valid2;

endmodule
